fallthrough_multi_queue_fifo: RTL and testbench
===============================================

# fallthrough_multi_queue_fifo

Single-clock, multi-channel first-word-fall-through FIFO: `NUM_QUEUES` independent queues of `2**MAX_DEPTH_BITS` entries each, sharing one statically partitioned register-array store. A write port and a read port each carry a queue index. The head word of the selected read queue is always presented on `dout`. This block is the next-generation small fallthrough FIFO for the output-queue path. It adds per-queue occupancy, programmable nearly-full/nearly-empty thresholds and sticky overflow/underflow error flags.

## Interface
Parameters:
- `WIDTH`, 72, data word width.
- `MAX_DEPTH_BITS`, 3, log2 of per-queue depth (depth D = 2**MAX_DEPTH_BITS).
- `NUM_QUEUES`, 4, number of queues (≥1, need not be a power of 2).
- `QUEUE_BITS`, 2, width of queue index (≥ ceil(log2(NUM_QUEUES)), ≥1).
- `NEARLY_FULL_THRESH`, D-1, nearly_full asserted when count ≥ this.
- `NEARLY_EMPTY_THRESH`, 1, nearly_empty asserted when count ≤ this.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  write data.
- `wr_en`  in  1  write strobe.
- `wr_queue`  in  QUEUE_BITS  target queue of write.
- `rd_en`  in  1  pop head of `rd_queue`.
- `rd_queue`  in  QUEUE_BITS  queue presented on `dout`/`rd_count`.
- `dout`  out  WIDTH  head word of `rd_queue` (fallthrough).
- `rd_count`  out  MAX_DEPTH_BITS+1  occupancy of `rd_queue`, 0..D.
- `full`  out  NUM_QUEUES  per-queue count == D.
- `nearly_full`  out  NUM_QUEUES  per-queue count ≥ NEARLY_FULL_THRESH.
- `empty`  out  NUM_QUEUES  per-queue count == 0.
- `nearly_empty`  out  NUM_QUEUES  per-queue count ≤ NEARLY_EMPTY_THRESH.
- `overflow`  out  NUM_QUEUES  sticky: write attempted to full queue.
- `underflow`  out  NUM_QUEUES  sticky: read attempted from empty queue.

## Operation
- Per queue q: write pointer, read pointer (MAX_DEPTH_BITS each, wrap modulo D), count (MAX_DEPTH_BITS+1 bits). Storage address = {q, ptr}.
- Write accepted iff `wr_en` and `wr_queue` < NUM_QUEUES and (count < D, or a read of the same queue is accepted in the same cycle). Accepted write stores `din` at the write pointer and increments the pointer.
- Read accepted iff `rd_en`, `rd_queue` < NUM_QUEUES and count ≥ 1 (pre-edge). Accepted read increments the read pointer.
- Count update per queue: +1 on write only, −1 on read only, unchanged when both or neither happen.
- Rejected write with a valid index and a full queue: data dropped, `overflow[q]` set. Rejected read with a valid index and an empty queue: no state change, `underflow[q]` set.
- Out-of-range queue index: request ignored, no flag set.
- Simultaneous rd+wr on the same full queue: both accepted, count stays D, no overflow.
- Simultaneous rd+wr on the same empty queue: the read is rejected with underflow, and the write is accepted. There is no same-cycle bypass.
- Write and read on different queues are fully independent.
- Flags are combinational decodes of the registered counts, so they change only after a clock edge. Sticky flags clear only on `reset`.
- `dout` = storage[{rd_queue, rd_ptr[rd_queue]}], combinational in `rd_queue`. Valid only when `empty[rd_queue]`=0. Otherwise it is don't-care.

## Timing
- Reset (`reset`=1 at edge): all pointers and counts 0. Outputs then read `empty`=all 1, `nearly_empty`=all 1 (when NEARLY_EMPTY_THRESH ≥ 0), `full`=0, `nearly_full`=0, `overflow`=0, `underflow`=0, `rd_count`=0.
- Storage is not reset. `reset` overrides any `wr_en`/`rd_en` in the same cycle. Reset mid-traffic discards all contents.
- Write latency: a word written at edge n is on `dout` (if it is the head) and `empty` deasserts in the cycle after edge n.
- Read: the head is visible before the edge. Popping at edge n presents the next entry in the cycle after edge n, with no bubble for back-to-back reads.
- Changing `rd_queue` switches `dout`/`rd_count` within the same cycle (combinational).
- Throughput: one write and one read per cycle, any queue combination.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 to queue 2 → `empty`=4'b1011, `rd_count`=3 with `rd_queue`=2, `dout`=0x11. Three reads give 0x22, 0x33, then `empty[2]`=1.
- With D=8, fill queue 0 with 8 words → `full[0]`=1 and `nearly_full[0]` asserted after the 7th write. A 9th write is dropped and `overflow[0]`=1 stays set. Reading returns the original 8 words in order.
- Empty queue 1, pulse `rd_en` with `rd_queue`=1 → `underflow[1]`=1, counts unchanged, other flags unaffected.
- Full queue 3: same-cycle rd+wr of 0xAA → `rd_count`=8, no overflow, and 0xAA emerges last. Empty queue 3: same-cycle rd+wr of 0xBB → underflow set, `rd_count`=1, `dout`=0xBB.
- Interleaved random writes and reads across all 4 queues for 10k cycles, including pointer wrap → data order per queue matches a scoreboard, and `rd_count` matches the model every cycle.
- Assert `reset` while queues are partially full with `wr_en`/`rd_en` active → next cycle all `empty`=1, all counts 0 and sticky flags cleared.

Source files
------------

// File: rtl/fallthrough_multi_queue_fifo_if.sv
// Bus bundle for the multi-queue fallthrough FIFO: write port, read port,
// the presented head word and the per-queue status vectors.
//
// Handshake: there is no ready signal. wr_en/rd_en are single-cycle request
// strobes qualified by wr_queue/rd_queue. A request counts as accepted at the
// rising edge where it is held high if the target queue can take it
// (write: not full, or a same-queue read pops in that cycle; read: not
// empty). A rejected request leaves the data and pointers untouched and sets
// the sticky overflow/underflow bit of that queue. Callers that must not
// lose data consult full/empty for the queue before strobing.
interface fallthrough_multi_queue_fifo_if #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_BITS     = 2
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic [QUEUE_BITS-1:0]   wr_queue;
  logic                    rd_en;
  logic [QUEUE_BITS-1:0]   rd_queue;
  logic [WIDTH-1:0]        dout;
  logic [MAX_DEPTH_BITS:0] rd_count;
  logic [NUM_QUEUES-1:0]   full;
  logic [NUM_QUEUES-1:0]   nearly_full;
  logic [NUM_QUEUES-1:0]   empty;
  logic [NUM_QUEUES-1:0]   nearly_empty;
  logic [NUM_QUEUES-1:0]   overflow;
  logic [NUM_QUEUES-1:0]   underflow;

  modport master (
    output din, wr_en, wr_queue, rd_en, rd_queue,
    input  dout, rd_count, full, nearly_full, empty, nearly_empty,
           overflow, underflow
  );

  modport slave (
    input  din, wr_en, wr_queue, rd_en, rd_queue,
    output dout, rd_count, full, nearly_full, empty, nearly_empty,
           overflow, underflow
  );
endinterface

// File: rtl/fallthrough_multi_queue_fifo.sv
// Multi-queue first-word-fall-through FIFO. NUM_QUEUES independent circular
// queues of 2**MAX_DEPTH_BITS words share one statically partitioned register
// array; queue q owns entries q*D .. q*D+D-1. The head of rd_queue is always
// driven combinationally on dout. Per-queue occupancy drives full/nearly_full/
// empty/nearly_empty; rejected requests latch sticky overflow/underflow bits.
module fallthrough_multi_queue_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int NUM_QUEUES          = 4,
  parameter int QUEUE_BITS          = 2,
  parameter int NEARLY_FULL_THRESH  = (1 << MAX_DEPTH_BITS) - 1,
  parameter int NEARLY_EMPTY_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  fallthrough_multi_queue_fifo_if.slave bus
);

  localparam int DEPTH   = 1 << MAX_DEPTH_BITS;
  localparam int CW      = MAX_DEPTH_BITS + 1;
  localparam int ENTRIES = NUM_QUEUES * DEPTH;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef logic [MAX_DEPTH_BITS-1:0] ptr_t;
  typedef logic [CW-1:0]             cnt_t;

  ptr_t wr_ptr_q [NUM_QUEUES];
  ptr_t wr_ptr_d [NUM_QUEUES];
  ptr_t rd_ptr_q [NUM_QUEUES];
  ptr_t rd_ptr_d [NUM_QUEUES];
  cnt_t cnt_q    [NUM_QUEUES];
  cnt_t cnt_d    [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] overflow_q, overflow_d;
  logic [NUM_QUEUES-1:0] underflow_q, underflow_d;

  // Word store; deliberately not reset, pointers/counts define validity.
  logic [WIDTH-1:0] mem_q [ENTRIES];

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [NUM_QUEUES-1:0] wr_sel, rd_sel, wr_acc, rd_acc;

  // Accept/reject decisions and next pointer, count and sticky-flag values.
  // An out-of-range queue index selects no queue, so it is silently ignored.
  always_comb begin
    mem_we      = 1'b0;
    mem_waddr   = '0;
    wr_sel      = '0;
    rd_sel      = '0;
    wr_acc      = '0;
    rd_acc      = '0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      cnt_d[q]    = cnt_q[q];

      wr_sel[q] = bus.wr_en && (bus.wr_queue == QUEUE_BITS'(q));
      rd_sel[q] = bus.rd_en && (bus.rd_queue == QUEUE_BITS'(q));
      // Read needs a word present before the edge: no empty-queue bypass.
      rd_acc[q] = rd_sel[q] && (cnt_q[q] != '0);
      // A full queue still takes a write when it pops in the same cycle.
      wr_acc[q] = wr_sel[q] && ((cnt_q[q] != cnt_t'(DEPTH)) || rd_acc[q]);

      if (wr_acc[q]) begin
        wr_ptr_d[q] = wr_ptr_q[q] + ptr_t'(1);
        mem_we      = 1'b1;
        mem_waddr   = AW'(q * DEPTH) + AW'(wr_ptr_q[q]);
      end
      if (rd_acc[q]) begin
        rd_ptr_d[q] = rd_ptr_q[q] + ptr_t'(1);
      end

      case ({wr_acc[q], rd_acc[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + cnt_t'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - cnt_t'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase

      if (wr_sel[q] && !wr_acc[q]) overflow_d[q]  = 1'b1;
      if (rd_sel[q] && !rd_acc[q]) underflow_d[q] = 1'b1;
    end
  end

  // Queue bookkeeping registers; reset empties every queue and clears flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        cnt_q[q]    <= '0;
      end
      overflow_q  <= '0;
      underflow_q <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        cnt_q[q]    <= cnt_d[q];
      end
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Word store write; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= bus.din;
    end
  end

  // Fallthrough head/occupancy mux for rd_queue and per-queue status decode.
  always_comb begin
    bus.dout         = '0;
    bus.rd_count     = '0;
    bus.full         = '0;
    bus.nearly_full  = '0;
    bus.empty        = '0;
    bus.nearly_empty = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (bus.rd_queue == QUEUE_BITS'(q)) begin
        bus.dout     = mem_q[AW'(q * DEPTH) + AW'(rd_ptr_q[q])];
        bus.rd_count = cnt_q[q];
      end
      bus.full[q]         = (cnt_q[q] == cnt_t'(DEPTH));
      bus.nearly_full[q]  = (int'(cnt_q[q]) >= NEARLY_FULL_THRESH);
      bus.empty[q]        = (cnt_q[q] == '0);
      bus.nearly_empty[q] = (int'(cnt_q[q]) <= NEARLY_EMPTY_THRESH);
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fallthrough_multi_queue_fifo.sv
// Bench for fallthrough_multi_queue_fifo: directed scenarios with literal
// expectations plus a long randomized run against per-queue reference queues.
module tb_fallthrough_multi_queue_fifo;

  localparam int W   = 72;
  localparam int MDB = 3;
  localparam int NQ  = 4;
  localparam int QB  = 2;
  localparam int D   = 1 << MDB;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fallthrough_multi_queue_fifo_if #(
    .WIDTH(W), .MAX_DEPTH_BITS(MDB), .NUM_QUEUES(NQ), .QUEUE_BITS(QB)
  ) bus ();

  fallthrough_multi_queue_fifo #(
    .WIDTH(W), .MAX_DEPTH_BITS(MDB), .NUM_QUEUES(NQ), .QUEUE_BITS(QB),
    .NEARLY_FULL_THRESH(D - 1), .NEARLY_EMPTY_THRESH(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q [NQ][$];
  logic [NQ-1:0] m_ovf = '0;
  logic [NQ-1:0] m_unf = '0;
  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, updated from the rules at each edge.
  always @(posedge clk) begin
    int  rq, wq;
    bit  ra, wa;
    if (reset) begin
      for (int q = 0; q < NQ; q++) exp_q[q].delete();
      m_ovf = '0;
      m_unf = '0;
    end else begin
      rq = int'(bus.rd_queue);
      wq = int'(bus.wr_queue);
      ra = bus.rd_en && (rq < NQ) && (exp_q[rq].size() > 0);
      if (bus.rd_en && (rq < NQ) && !ra) m_unf[rq] = 1'b1;
      wa = bus.wr_en && (wq < NQ) && ((exp_q[wq].size() < D) || (ra && rq == wq));
      if (bus.wr_en && (wq < NQ) && !wa) m_ovf[wq] = 1'b1;
      if (ra) void'(exp_q[rq].pop_front());
      if (wa) exp_q[wq].push_back(bus.din);
    end
  end

  // Every-cycle compare of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    logic [NQ-1:0] e_full, e_nf, e_empty, e_ne;
    int rq, sz;
    if (chk_on) begin
      for (int q = 0; q < NQ; q++) begin
        sz = exp_q[q].size();
        e_full[q]  = (sz == D);
        e_nf[q]    = (sz >= D - 1);
        e_empty[q] = (sz == 0);
        e_ne[q]    = (sz <= 1);
      end
      check("full", bus.full, e_full);
      check("nearly_full", bus.nearly_full, e_nf);
      check("empty", bus.empty, e_empty);
      check("nearly_empty", bus.nearly_empty, e_ne);
      check("overflow", bus.overflow, m_ovf);
      check("underflow", bus.underflow, m_unf);
      rq = int'(bus.rd_queue);
      if (rq < NQ) begin
        check("rd_count", bus.rd_count, W'(exp_q[rq].size()));
        if (exp_q[rq].size() > 0) check("dout", bus.dout, exp_q[rq][0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit we, input int wq, input logic [W-1:0] d,
                       input bit re, input int rq);
    bus.wr_en    = we;
    bus.wr_queue = QB'(wq);
    bus.din      = d;
    bus.rd_en    = re;
    bus.rd_queue = QB'(rq);
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input int rq);
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_queue = QB'(rq);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = '0;
    bus.wr_queue = '0; bus.rd_queue = '0;
    reset = 1'b1;
    drive(0, 0, '0, 0, 0);
    drive(0, 0, '0, 0, 0);
    reset = 1'b0;
    chk_on = 1'b1;

    // Reset state
    peek(0);
    check("rst_empty", bus.empty, 4'b1111);
    check("rst_nearly_empty", bus.nearly_empty, 4'b1111);
    check("rst_full", bus.full, 4'b0000);
    check("rst_rd_count", bus.rd_count, 0);

    // Three words into queue 2, then drain
    drive(1, 2, 'h11, 0, 2);
    drive(1, 2, 'h22, 0, 2);
    drive(1, 2, 'h33, 0, 2);
    peek(2);
    check("q2_empty", bus.empty, 4'b1011);
    check("q2_count", bus.rd_count, 3);
    check("q2_head", bus.dout, 'h11);
    drive(0, 0, '0, 1, 2);
    peek(2);
    check("q2_pop1", bus.dout, 'h22);
    drive(0, 0, '0, 1, 2);
    peek(2);
    check("q2_pop2", bus.dout, 'h33);
    drive(0, 0, '0, 1, 2);
    peek(2);
    check("q2_drained", bus.empty[2], 1'b1);

    // Fill queue 0, overflow it, read back in order
    for (int i = 0; i < D; i++) begin
      drive(1, 0, W'('hA0 + i), 0, 0);
      if (i == D - 2) begin
        peek(0);
        check("q0_nf_at7", bus.nearly_full[0], 1'b1);
        check("q0_notfull_at7", bus.full[0], 1'b0);
      end
    end
    peek(0);
    check("q0_full", bus.full[0], 1'b1);
    check("q0_count8", bus.rd_count, 8);
    drive(1, 0, 'hFF, 0, 0);
    peek(0);
    check("q0_overflow", bus.overflow, 4'b0001);
    check("q0_count_kept", bus.rd_count, 8);
    for (int i = 0; i < D; i++) begin
      peek(0);
      check("q0_order", bus.dout, W'('hA0 + i));
      drive(0, 0, '0, 1, 0);
    end
    peek(0);
    check("q0_empty_after", bus.empty[0], 1'b1);
    check("q0_ovf_sticky", bus.overflow[0], 1'b1);

    // Underflow on empty queue 1
    drive(0, 0, '0, 1, 1);
    peek(1);
    check("q1_underflow", bus.underflow, 4'b0010);
    check("q1_count", bus.rd_count, 0);
    check("q1_empty_all", bus.empty, 4'b1111);
    check("q1_ovf_untouched", bus.overflow, 4'b0001);

    // Full queue 3: same-cycle read+write
    for (int i = 0; i < D; i++) drive(1, 3, W'('hC0 + i), 0, 3);
    drive(1, 3, 'hAA, 1, 3);
    peek(3);
    check("q3_full_rw_count", bus.rd_count, 8);
    check("q3_no_ovf", bus.overflow[3], 1'b0);
    check("q3_head_after_rw", bus.dout, 'hC1);
    for (int i = 1; i <= D; i++) begin
      peek(3);
      check("q3_drain", bus.dout, (i == D) ? W'('hAA) : W'('hC0 + i));
      drive(0, 0, '0, 1, 3);
    end
    // Empty queue 3: same-cycle read+write, read must be rejected
    drive(1, 3, 'hBB, 1, 3);
    peek(3);
    check("q3_empty_rw_unf", bus.underflow[3], 1'b1);
    check("q3_empty_rw_count", bus.rd_count, 1);
    check("q3_empty_rw_dout", bus.dout, 'hBB);
    drive(0, 0, '0, 1, 3);

    // Randomized traffic in fill / drain / balanced phases
    for (int c = 0; c < 10000; c++) begin
      int pw, pr;
      case ((c / 400) % 3)
        0:       begin pw = 85; pr = 30; end
        1:       begin pw = 30; pr = 85; end
        default: begin pw = 60; pr = 60; end
      endcase
      drive($urandom_range(0, 99) < pw, $urandom_range(0, NQ - 1),
            W'({$urandom(), $urandom(), $urandom()}),
            $urandom_range(0, 99) < pr, $urandom_range(0, NQ - 1));
    end

    // Reset in the middle of traffic
    for (int i = 0; i < 5; i++) drive(1, i % NQ, W'(i + 'h300), 0, 0);
    reset = 1'b1;
    drive(1, 1, 'h55, 1, 0);
    reset = 1'b0;
    peek(0);
    check("mid_rst_empty", bus.empty, 4'b1111);
    check("mid_rst_count", bus.rd_count, 0);
    check("mid_rst_ovf", bus.overflow, 4'b0000);
    check("mid_rst_unf", bus.underflow, 4'b0000);
    check("mid_rst_full", bus.full, 4'b0000);
    drive(0, 0, '0, 0, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
